// File: rtl/edabk_uart_pkg.sv
// Shared UART definitions: controller state encoding, stop-bit limits and
// frame-length arithmetic used by both the transmit and receive controllers.
package edabk_uart_pkg;

  localparam int CFG_DATA_WIDTH = 8;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_ctrl_state_e;

  // Total bit periods on the line for one frame: start + data + parity + stop.
  function automatic int frame_bits(input int data_width, input logic parity_en,
                                    input int stop_bits);
    return 1 + data_width + (parity_en ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/edabk_transmitter_controller.sv
// UART transmit sequencer. Accepts one byte per tx_start/tx_ready handshake,
// then counts datapath done pulses across the frame, issuing load on accept,
// shift between bits and clear at frame end or abort.
//
//   state   | meaning
//   TX_IDLE | ready for a host request; load mirrors tx_start
//   TX_SEND | frame on the line; each done advances one bit period
module edabk_transmitter_controller
  import edabk_uart_pkg::*;
#(
  parameter int DATA_WIDTH = CFG_DATA_WIDTH,
  parameter int STOP_BITS  = 1,
  parameter int BCNT_WIDTH = $clog2(DATA_WIDTH + 4)
) (
  input  logic bclk,
  input  logic reset_n,
  input  logic tx_start,
  input  logic parity_en,
  input  logic tx_abort,
  input  logic done,
  output logic tx_ready,
  output logic tx_busy,
  output logic tx_done,
  output logic load,
  output logic shift,
  output logic clear,
  output logic parity
);

  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("edabk_transmitter_controller: STOP_BITS must be 1 or 2");
  end

  // Index of the final bit period, with and without the parity bit.
  localparam int LAST_NOPAR = frame_bits(DATA_WIDTH, 1'b0, STOP_BITS) - 1;
  localparam int LAST_PAR   = frame_bits(DATA_WIDTH, 1'b1, STOP_BITS) - 1;

  tx_ctrl_state_e        state_q, state_d;
  logic [BCNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [BCNT_WIDTH-1:0] frame_last_q, frame_last_d;
  logic                  tx_done_q, tx_done_d;
  logic                  last_bit;

  assign last_bit = (bit_cnt_q == frame_last_q);

  // Next-state and Mealy strobe decode; abort outranks a coincident done.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    frame_last_d = frame_last_q;
    tx_done_d    = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
    clear        = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (tx_start) begin
          load         = 1'b1;
          state_d      = TX_SEND;
          bit_cnt_d    = '0;
          frame_last_d = parity_en ? BCNT_WIDTH'(LAST_PAR) : BCNT_WIDTH'(LAST_NOPAR);
        end
      end
      TX_SEND: begin
        if (tx_abort) begin
          clear   = 1'b1;
          state_d = TX_IDLE;
        end else if (done) begin
          if (last_bit) begin
            clear     = 1'b1;
            state_d   = TX_IDLE;
            tx_done_d = 1'b1;
          end else begin
            shift     = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // State, bit counter, frame length and completion pulse registers.
  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= TX_IDLE;
      bit_cnt_q    <= '0;
      frame_last_q <= '0;
      tx_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_last_q <= frame_last_d;
      tx_done_q    <= tx_done_d;
    end
  end

  assign tx_ready = (state_q == TX_IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx_done  = tx_done_q;
  assign parity   = parity_en;

endmodule

// File: tb/tb_edabk_transmitter_controller.sv
// Bench for the transmit controller: two instances (one and two stop bits)
// share host stimulus; each gets done pulses from a bench bit-period timer.
module tb_edabk_transmitter_controller;

  localparam int CLK_DIV = 16;
  localparam int DW      = 8;

  logic bclk = 1'b0;
  logic reset_n;
  logic tx_start, parity_en, tx_abort, extra_done;
  logic done     [2];
  logic tx_ready [2];
  logic tx_busy  [2];
  logic tx_done  [2];
  logic load     [2];
  logic shift    [2];
  logic clear    [2];
  logic parity   [2];

  always #5 bclk = ~bclk;

  edabk_transmitter_controller #(.DATA_WIDTH(DW), .STOP_BITS(1)) u_dut1 (
    .bclk(bclk), .reset_n(reset_n), .tx_start(tx_start), .parity_en(parity_en),
    .tx_abort(tx_abort), .done(done[0]), .tx_ready(tx_ready[0]), .tx_busy(tx_busy[0]),
    .tx_done(tx_done[0]), .load(load[0]), .shift(shift[0]), .clear(clear[0]),
    .parity(parity[0]));

  edabk_transmitter_controller #(.DATA_WIDTH(DW), .STOP_BITS(2)) u_dut2 (
    .bclk(bclk), .reset_n(reset_n), .tx_start(tx_start), .parity_en(parity_en),
    .tx_abort(tx_abort), .done(done[1]), .tx_ready(tx_ready[1]), .tx_busy(tx_busy[1]),
    .tx_done(tx_done[1]), .load(load[1]), .shift(shift[1]), .clear(clear[1]),
    .parity(parity[1]));

  // Frame-level model: frame in flight, its length, done pulses seen so far,
  // cycles elapsed since accept, and the pending completion pulse.
  int stops [2] = '{1, 2};
  bit m_busy [2];
  int m_nbits [2];
  int m_dones [2];
  int m_k [2];
  bit m_txdone [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int n_acc [2];
  int n_txd [2];
  int acc_e [2][4];
  int done_e [2][4];

  task automatic chk(input string name, input int lane, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got %b expected %b (cycle %0d)", lane, name, got, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_busy[l] = 0; m_nbits[l] = 0; m_dones[l] = 0; m_k[l] = 0; m_txdone[l] = 0;
    end
  endtask

  task automatic clr_obs();
    for (int l = 0; l < 2; l++) begin
      n_acc[l] = 0; n_txd[l] = 0;
      for (int i = 0; i < 4; i++) begin acc_e[l][i] = -1; done_e[l][i] = -1; end
    end
  endtask

  // A bit period ends every CLK_DIV cycles after accept.
  task automatic drive_done();
    for (int l = 0; l < 2; l++)
      done[l] = (reset_n && m_busy[l] && (m_k[l] % CLK_DIV == CLK_DIV - 1)) || extra_done;
  endtask

  // One bclk cycle: drive, compare all outputs against the model, advance.
  task automatic step();
    bit last;
    drive_done();
    #1;
    for (int l = 0; l < 2; l++) begin
      last = (m_dones[l] == m_nbits[l] - 1);
      chk("tx_ready", l, tx_ready[l], !m_busy[l]);
      chk("tx_busy",  l, tx_busy[l],  m_busy[l]);
      chk("tx_done",  l, tx_done[l],  m_txdone[l]);
      chk("load",     l, load[l],     !m_busy[l] && tx_start);
      chk("clear",    l, clear[l],    m_busy[l] && (tx_abort || (done[l] && last)));
      chk("shift",    l, shift[l],    m_busy[l] && !tx_abort && done[l] && !last);
      chk("parity",   l, parity[l],   parity_en);
      if (load[l] === 1'b1 && n_acc[l] < 4) begin acc_e[l][n_acc[l]] = cyc + 1; n_acc[l]++; end
      if (tx_done[l] === 1'b1) begin
        if (n_txd[l] < 4) done_e[l][n_txd[l]] = cyc;
        n_txd[l]++;
      end
    end
    @(posedge bclk);
    cyc++;
    if (reset_n) begin
      for (int l = 0; l < 2; l++) begin
        m_txdone[l] = 0;
        if (!m_busy[l]) begin
          if (tx_start) begin
            m_busy[l] = 1; m_nbits[l] = 1 + DW + (parity_en ? 1 : 0) + stops[l];
            m_dones[l] = 0; m_k[l] = 0;
          end
        end else begin
          if (tx_abort) m_busy[l] = 0;
          else if (done[l]) begin
            if (m_dones[l] == m_nbits[l] - 1) begin m_busy[l] = 0; m_txdone[l] = 1; end
            else m_dones[l]++;
          end
          m_k[l]++;
        end
      end
    end
    @(negedge bclk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic step_until_k(input int target);
    int n = 0;
    while (m_k[0] != target && n < 300) begin step(); n++; end
    chk_int("wait_bit_position", m_k[0], target);
  endtask

  task automatic run_frame(input logic pen);
    clr_obs();
    parity_en = pen;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    steps(200);
  endtask

  initial begin
    reset_n = 1'b1; tx_start = 1'b0; parity_en = 1'b0; tx_abort = 1'b0; extra_done = 1'b0;
    done[0] = 1'b0; done[1] = 1'b0;
    model_reset();
    clr_obs();
    #2 reset_n = 1'b0;
    @(negedge bclk);
    #1;
    chk("reset tx_ready", 0, tx_ready[0], 1'b1);
    chk("reset tx_busy", 1, tx_busy[1], 1'b0);
    steps(3);
    reset_n = 1'b1;
    steps(2);

    // done and abort while idle change nothing
    extra_done = 1'b1; tx_abort = 1'b1;
    step();
    extra_done = 1'b0; tx_abort = 1'b0;
    step();
    chk("idle ignores done/abort", 0, tx_ready[0], 1'b1);

    // basic frame, no parity
    run_frame(1'b0);
    chk_int("basic frame len stop1", done_e[0][0] - acc_e[0][0], 160);
    chk_int("basic frame len stop2", done_e[1][0] - acc_e[1][0], 176);
    chk_int("basic tx_done count stop1", n_txd[0], 1);
    chk_int("basic tx_done count stop2", n_txd[1], 1);

    // parity frame
    run_frame(1'b1);
    chk_int("parity frame len stop1", done_e[0][0] - acc_e[0][0], 176);
    chk_int("parity frame len stop2", done_e[1][0] - acc_e[1][0], 192);
    parity_en = 1'b0;

    // back-to-back with tx_start held high
    clr_obs();
    tx_start = 1'b1;
    steps(360);
    tx_start = 1'b0;
    steps(220);
    chk_int("b2b gap stop1", done_e[0][1] - done_e[0][0], 161);
    chk_int("b2b gap stop2", done_e[1][1] - done_e[1][0], 177);
    chk_int("b2b reload after clear stop1", acc_e[0][1] - done_e[0][0], 1);
    chk_int("b2b reload after clear stop2", acc_e[1][1] - done_e[1][0], 1);

    // abort in the middle of data bit 3
    clr_obs();
    tx_start = 1'b1; step(); tx_start = 1'b0;
    step_until_k(70);
    tx_abort = 1'b1;
    drive_done(); #1;
    chk("abort clear", 0, clear[0], 1'b1);
    chk("abort shift", 0, shift[0], 1'b0);
    step();
    tx_abort = 1'b0;
    #1;
    chk("abort ready next", 0, tx_ready[0], 1'b1);
    steps(200);
    chk_int("abort no tx_done", n_txd[0] + n_txd[1], 0);

    // abort coincident with done
    clr_obs();
    tx_start = 1'b1; step(); tx_start = 1'b0;
    step_until_k(47);
    tx_abort = 1'b1;
    drive_done(); #1;
    chk("coincident done present", 0, done[0], 1'b1);
    chk("coincident shift", 0, shift[0], 1'b0);
    chk("coincident clear", 0, clear[0], 1'b1);
    step();
    tx_abort = 1'b0;
    steps(200);
    chk_int("coincident no tx_done", n_txd[0] + n_txd[1], 0);

    // reset in the middle of data bit 4 (line bit 5)
    clr_obs();
    tx_start = 1'b1; step(); tx_start = 1'b0;
    step_until_k(88);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midreset tx_ready", 0, tx_ready[0], 1'b1);
    chk("midreset tx_busy", 0, tx_busy[0], 1'b0);
    chk("midreset tx_ready", 1, tx_ready[1], 1'b1);
    @(negedge bclk);
    steps(3);
    reset_n = 1'b1;
    steps(2);
    chk_int("midreset no tx_done", n_txd[0] + n_txd[1], 0);
    run_frame(1'b0);
    chk_int("post-reset frame len stop1", done_e[0][0] - acc_e[0][0], 160);
    chk_int("post-reset tx_done count", n_txd[0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
